// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the sequential ALU: opcode encoding, flag bundle, FSM
// state encoding and the highest legal opcode.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcodes 0-3 keep the legacy combinational ALU encodings.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_NOTB = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_MUL  = 4'd8
    } alu_op_e;

    localparam alu_op_e ALU_OP_LAST = OP_MUL;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Opcodes above ALU_OP_LAST produce a zero result with op_err set.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// The first partial product is folded in on the start edge, so the full
// product is ready WIDTH-1 cycles later and done pulses for one cycle then.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           load a/b and begin a new multiply
//   a, b            WIDTH-bit unsigned operands (sampled on start)
//   done            one-cycle pulse: prod holds the complete product
//   prod            2*WIDTH-bit product accumulator
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               done_r;

    // Shift-add datapath and remaining-step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            done_r   <= 1'b0;
        end else if (start) begin
            // Step 0 happens here using b[0]; WIDTH-1 steps remain.
            acc_r    <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
            mcand_r  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_r <= {1'b0, b[WIDTH-1:1]};
            cnt_r    <= CNT_W'(WIDTH - 1);
            done_r   <= 1'b0;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_W'(1);
            done_r   <= (cnt_r == CNT_W'(1));
        end else begin
            done_r   <= 1'b0;
        end
    end

    assign done = done_r;
    assign prod = acc_r;

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Handshaked ALU with registered result and Z/N/C/V flags. Single-cycle ops
// complete on the accept edge; MUL iterates WIDTH cycles in alu_mul_seq.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake (in_ready is combinational
//                         from out_ready so DONE can hand off back-to-back)
//   val_A, val_B, ALU_op  operands and opcode, sampled only at accept
//   out_valid / out_ready result handshake
//   ALU_out, Z, N, C, V   registered result and flags
//   op_err                result came from an illegal opcode
// -----------------------------------------------------------------------------
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_A,
    input  logic [WIDTH-1:0] val_B,
    input  logic [3:0]       ALU_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             op_err
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e         state_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   alu_out_r;
    alu_flags_t         flags_r;
    logic               op_err_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               mul_start_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     shr_s;
    logic [SW-1:0]      sh_amt_s;
    logic [WIDTH-1:0]   res_s;
    logic               c_s;
    logic               v_s;
    logic               err_s;
    alu_flags_t         flags_s;

    assign in_ready_s  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign accept_s    = in_valid & in_ready_s;
    assign mul_start_s = accept_s & (ALU_op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start_s),
        .a     (val_A),
        .b     (val_B),
        .done  (mul_done_s),
        .prod  (mul_prod_s)
    );

    // Next result and flags: multiplier output while BUSY, else decoded op.
    always_comb begin
        sum_s    = {1'b0, val_A} + {1'b0, val_B};
        diff_s   = {1'b0, val_A} - {1'b0, val_B};
        sh_amt_s = val_B[SW-1:0];
        // One guard bit catches the last bit shifted out in either direction.
        shl_s    = {1'b0, val_A} << sh_amt_s;
        shr_s    = {val_A, 1'b0} >> sh_amt_s;
        res_s    = {WIDTH{1'b0}};
        c_s      = 1'b0;
        v_s      = 1'b0;
        err_s    = 1'b0;
        if (state_r == ST_BUSY) begin
            res_s = mul_prod_s[WIDTH-1:0];
            c_s   = |mul_prod_s[2*WIDTH-1:WIDTH];
        end else begin
            err_s = ~op_is_legal(ALU_op);
            case (ALU_op)
                OP_ADD: begin
                    res_s = sum_s[WIDTH-1:0];
                    c_s   = sum_s[WIDTH];
                    v_s   = (val_A[WIDTH-1] == val_B[WIDTH-1]) &
                            (sum_s[WIDTH-1] != val_A[WIDTH-1]);
                end
                OP_SUB: begin
                    res_s = diff_s[WIDTH-1:0];
                    c_s   = ~diff_s[WIDTH];
                    v_s   = (val_A[WIDTH-1] != val_B[WIDTH-1]) &
                            (diff_s[WIDTH-1] != val_A[WIDTH-1]);
                end
                OP_AND:  res_s = val_A & val_B;
                OP_NOTB: res_s = ~val_B;
                OP_OR:   res_s = val_A | val_B;
                OP_XOR:  res_s = val_A ^ val_B;
                OP_SHL: begin
                    res_s = shl_s[WIDTH-1:0];
                    c_s   = shl_s[WIDTH];
                end
                OP_SHR: begin
                    res_s = shr_s[WIDTH:1];
                    c_s   = shr_s[0];
                end
                default: begin
                    // MUL result is produced in BUSY; illegal opcodes give zero.
                    res_s = {WIDTH{1'b0}};
                end
            endcase
        end
        flags_s.z = (res_s == {WIDTH{1'b0}});
        flags_s.n = res_s[WIDTH-1];
        flags_s.c = c_s;
        flags_s.v = v_s;
    end

    // Handshake FSM and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            alu_out_r   <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            op_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (mul_start_s) begin
                            state_r <= ST_BUSY;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            alu_out_r   <= res_s;
                            flags_r     <= flags_s;
                            op_err_r    <= err_s;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mul_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        alu_out_r   <= res_s;
                        flags_r     <= flags_s;
                        op_err_r    <= err_s;
                    end
                end
                ST_DONE: begin
                    // Without out_ready everything holds.
                    if (out_ready) begin
                        if (accept_s) begin
                            if (mul_start_s) begin
                                state_r     <= ST_BUSY;
                                out_valid_r <= 1'b0;
                            end else begin
                                alu_out_r   <= res_s;
                                flags_r     <= flags_s;
                                op_err_r    <= err_s;
                            end
                        end else begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign ALU_out   = alu_out_r;
    assign Z         = flags_r.z;
    assign N         = flags_r.n;
    assign C         = flags_r.c;
    assign V         = flags_r.v;
    assign op_err    = op_err_r;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed bench for seq_alu (WIDTH=16) with a cycle-level reference model
// of the handshake and an arithmetic model of the opcode set.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  val_A;
    logic [W-1:0]  val_B;
    logic [3:0]    ALU_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ALU_out;
    logic          Z, N, C, V, op_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] r;
        logic        z, n, c, v, e;
    } exp_t;

    exp_t m_out;
    exp_t m_pend;
    bit   m_valid = 1'b0;
    int   m_busy  = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .val_A     (val_A),
        .val_B     (val_B),
        .ALU_op    (ALU_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_out   (ALU_out),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Arithmetic meaning of each opcode, using plain integer ranges.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint ua, ub, sa, sb, full, s;
        int     sh;
        ua = a; ub = b;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sh = int'(b[3:0]);
        e.r = 16'h0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0;
        case (op)
            4'd0: begin
                full = ua + ub; e.r = full[15:0]; e.c = (full > 65535);
                s = sa + sb; e.v = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                full = ua - ub; e.r = full[15:0]; e.c = (ua >= ub);
                s = sa - sb; e.v = (s > 32767) || (s < -32768);
            end
            4'd2: e.r = a & b;
            4'd3: e.r = ~b;
            4'd4: e.r = a | b;
            4'd5: e.r = a ^ b;
            4'd6: begin
                e.r = a << sh;
                e.c = (sh == 0) ? 1'b0 : (((ua >> (16 - sh)) & 1) != 0);
            end
            4'd7: begin
                e.r = a >> sh;
                e.c = (sh == 0) ? 1'b0 : (((ua >> (sh - 1)) & 1) != 0);
            end
            4'd8: begin
                full = ua * ub; e.r = full[15:0]; e.c = ((full >> 16) != 0);
            end
            default: e.e = 1'b1;
        endcase
        e.z = (e.r == 16'h0);
        e.n = e.r[15];
        return e;
    endfunction

    // Every-cycle comparison against the model, then advance the model to
    // what must hold after the coming rising edge.
    always @(negedge clk) begin : mon
        bit exp_rdy;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_busy  = 0;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_alu_out", {16'd0, ALU_out}, 32'd0);
            check("rst_flags", {27'd0, Z, N, C, V, op_err}, 32'd0);
        end else begin
            exp_rdy = (m_busy == 0) && (!m_valid || out_ready);
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("alu_out", {16'd0, ALU_out}, {16'd0, m_out.r});
                check("flags_ZNCV_err", {27'd0, Z, N, C, V, op_err},
                      {27'd0, m_out.z, m_out.n, m_out.c, m_out.v, m_out.e});
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1'b1;
                    m_out   = m_pend;
                end
            end else if (m_valid && !out_ready) begin
                m_valid = m_valid;
            end else if (in_valid && exp_rdy) begin
                if (ALU_op == 4'd8) begin
                    m_pend  = model(ALU_op, val_A, val_B);
                    m_busy  = W;
                    m_valid = 1'b0;
                end else begin
                    m_out   = model(ALU_op, val_A, val_B);
                    m_valid = 1'b1;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // Present one operation; returns one time unit after its accept edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bit ok;
        bit acc;
        acc = 1'b0;
        val_A = a; val_B = b; ALU_op = op; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1 ok = in_ready;
            @(posedge clk);
            if (ok) begin
                acc = 1'b1;
                break;
            end
        end
        #1 in_valid = 1'b0;
        check("accept_within_budget", {31'd0, acc}, 32'd1);
    endtask

    // Wait for out_valid; counts stalled cycles, realigns after the next edge.
    task automatic wait_result(output int busy_cycles, output exp_t got);
        bit found;
        found = 1'b0;
        busy_cycles = 0;
        got.r = 16'h0; got.z = 1'b0; got.n = 1'b0; got.c = 1'b0; got.v = 1'b0; got.e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                got.r = ALU_out; got.z = Z; got.n = N; got.c = C; got.v = V; got.e = op_err;
                break;
            end else if (!in_ready) begin
                busy_cycles++;
            end
        end
        check("result_within_budget", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t g;
        exp_t pm;
        int   bc;
        int   cnt;

        // Pin the arithmetic model to hand-computed values.
        pm = model(4'd0, 16'h7FFF, 16'h0001);
        check("pin_add", {16'd0, pm.r, 11'd0, pm.n, pm.v, pm.c, pm.z, pm.e}, {16'h8000, 16'h0018});
        pm = model(4'd1, 16'h0003, 16'h0004);
        check("pin_sub", {16'd0, pm.r, 11'd0, pm.n, pm.v, pm.c, pm.z, pm.e}, {16'hFFFF, 16'h0010});
        pm = model(4'd8, 16'h0100, 16'h0100);
        check("pin_mul", {16'd0, pm.r, 11'd0, pm.n, pm.v, pm.c, pm.z, pm.e}, {16'h0000, 16'h0006});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        val_A = 16'h0; val_B = 16'h0; ALU_op = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        issue(4'd0, 16'h7FFF, 16'h0001);
        wait_result(bc, g);
        check("add_out", {16'd0, g.r}, 32'h8000);
        check("add_ZNCV", {28'd0, g.z, g.n, g.c, g.v}, 32'b0101);

        issue(4'd1, 16'h0005, 16'h0005);
        wait_result(bc, g);
        check("sub_eq_out", {16'd0, g.r}, 32'h0000);
        check("sub_eq_ZC", {30'd0, g.z, g.c}, 32'b11);
        issue(4'd1, 16'h0003, 16'h0004);
        wait_result(bc, g);
        check("sub_lt_out", {16'd0, g.r}, 32'hFFFF);
        check("sub_lt_NC", {30'd0, g.n, g.c}, 32'b10);

        issue(4'd6, 16'h8001, 16'h0001);
        wait_result(bc, g);
        check("shl_out", {16'd0, g.r}, 32'h0002);
        check("shl_C", {31'd0, g.c}, 32'd1);
        issue(4'd7, 16'h0001, 16'h0000);
        wait_result(bc, g);
        check("shr0_out", {16'd0, g.r}, 32'h0001);
        check("shr0_C", {31'd0, g.c}, 32'd0);

        issue(4'd8, 16'h0100, 16'h0100);
        wait_result(bc, g);
        check("mul_busy_cycles", bc, 32'd16);
        check("mul_big_out", {16'd0, g.r}, 32'h0000);
        check("mul_big_ZC", {30'd0, g.z, g.c}, 32'b11);
        issue(4'd8, 16'h0003, 16'h0005);
        wait_result(bc, g);
        check("mul_small_out", {16'd0, g.r}, 32'h000F);
        check("mul_small_C", {31'd0, g.c}, 32'd0);

        // Back-to-back single-cycle ops, one per clock; checked by the model.
        issue(4'd4, 16'hA500, 16'h005A);
        issue(4'd5, 16'hFFFF, 16'h1234);
        issue(4'd3, 16'h0000, 16'h00FF);
        issue(4'd2, 16'hFF00, 16'h0FF0);
        issue(4'd7, 16'h8000, 16'h000F);
        issue(4'd6, 16'h1234, 16'h0004);
        issue(4'd0, 16'hFFFF, 16'h0001);
        issue(4'd1, 16'h8000, 16'h0001);
        issue(4'hF, 16'h1111, 16'h2222);
        issue(4'd8, 16'hFFFF, 16'hFFFF);
        wait_result(bc, g);
        check("mul_max_out", {16'd0, g.r}, 32'h0001);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(4'd2, 16'hF0F0, 16'h3C3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out", {16'd0, ALU_out}, 32'h3030);
            check("bp_valid_ready", {30'd0, out_valid, in_ready}, 32'b10);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(4'd5, 16'h00FF, 16'h0F0F);
        wait_result(bc, g);
        check("xor_after_bp", {16'd0, g.r}, 32'h0FF0);

        issue(4'hC, 16'h1234, 16'h5678);
        wait_result(bc, g);
        check("illegal_out", {16'd0, g.r}, 32'h0000);
        check("illegal_Z_err", {30'd0, g.z, g.e}, 32'b11);

        // Reset in the middle of a multiply.
        issue(4'd8, 16'h0003, 16'h0005);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("midmul_rst_valid_ready", {30'd0, out_valid, in_ready}, 32'b01);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("no_result_after_rst", cnt, 32'd0);
        @(posedge clk);
        #1;
        issue(4'd0, 16'h0001, 16'h0002);
        wait_result(bc, g);
        check("add_after_rst", {16'd0, g.r}, 32'h0003);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
